// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and bus width defaults for mem_port_arbiter
package mem_port_arbiter_pkg;

  localparam int MEM_ARB_AW = 32;
  localparam int MEM_ARB_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// rtl/mem_port_arbiter_arb_pick.sv - fetch/data priority selector with starvation streak counter
module arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_idle,
  input  logic i_fetch_req,
  input  logic i_data_req,
  output logic o_pick_fetch,
  output logic o_pick_data
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  logic [SW-1:0] r_streak;
  logic          w_starve;

  assign w_starve     = (r_streak == STREAK_MAX) && i_fetch_req;
  assign o_pick_data  = i_data_req && !w_starve;
  assign o_pick_fetch = i_fetch_req && (!i_data_req || w_starve);

  // Streak only moves when a grant is actually issued out of IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_streak <= '0;
    end else if (i_idle) begin
      if (o_pick_data) begin
        if (!i_fetch_req)
          r_streak <= '0;
        else if (r_streak != STREAK_MAX)
          r_streak <= r_streak + 1'b1;
      end else if (o_pick_fetch) begin
        r_streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serializes fetch and load/store accesses onto one memory port
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = MEM_ARB_AW,
  parameter int DW         = MEM_ARB_DW,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_valid,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy
);

  arb_state_e    r_state;
  logic          r_busy;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_i_gnt, r_d_gnt;
  logic          r_i_valid, r_d_valid;
  logic [DW-1:0] r_i_rdata, r_d_rdata;
  logic          r_i_err, r_d_err;

  logic          w_idle;
  logic          w_pick_i, w_pick_d;
  logic          w_expire;
  logic          w_done;

  assign w_idle = (r_state == IDLE);
  assign w_done = r_busy && (mem_ack || w_expire);

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk          (clk),
    .reset        (reset),
    .i_idle       (w_idle),
    .i_fetch_req  (i_req),
    .i_data_req   (d_req),
    .o_pick_fetch (w_pick_i),
    .o_pick_data  (w_pick_d)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] r_wdog;

  // Expiry on the TIMEOUT-th unacknowledged BUSY cycle; a same-cycle ack wins.
  assign w_expire = r_busy && !mem_ack && (r_wdog == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_wdog <= '0;
    else if (!r_busy || mem_ack || w_expire)
      r_wdog <= '0;
    else
      r_wdog <= r_wdog + 1'b1;
  end
`else
  assign w_expire = 1'b0;

  if (TIMEOUT < 1) begin : g_timeout_range
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_gnt     <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_i_valid   <= 1'b0;
      r_d_valid   <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_err     <= 1'b0;
      r_d_err     <= 1'b0;
    end else begin
      r_i_gnt   <= 1'b0;
      r_d_gnt   <= 1'b0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state     <= DBUSY;
            r_busy      <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_d_gnt     <= 1'b1;
          end else if (w_pick_i) begin
            r_state     <= IBUSY;
            r_busy      <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= i_addr;
            r_mem_wdata <= '0;
            r_i_gnt     <= 1'b1;
          end
        end
        IBUSY, DBUSY: begin
          if (w_done) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_mem_req <= 1'b0;
            if (r_state == IBUSY) begin
              r_i_valid <= 1'b1;
              r_i_err   <= !mem_ack;
              r_i_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              r_d_valid <= 1'b1;
              r_d_err   <= !mem_ack;
              r_d_rdata <= (mem_ack && !r_mem_we) ? mem_rdata : '0;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign i_gnt     = r_i_gnt;
  assign i_valid   = r_i_valid;
  assign i_rdata   = r_i_rdata;
  assign i_err     = r_i_err;
  assign d_gnt     = r_d_gnt;
  assign d_valid   = r_d_valid;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_valid, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_valid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;

  int n_cmp;
  int n_bad;

  mem_port_arbiter #(
    .AW         (32),
    .DW         (32),
    .STARVE_MAX (4),
    .TIMEOUT    (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_valid   (i_valid),
    .i_rdata   (i_rdata),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    step(); step();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnts", {i_gnt, d_gnt}, 0);
    chk("rst_valids", {i_valid, d_valid}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    reset = 1'b0;
    step();

    // single fetch, memory acks in its first cycle; ack stays high while idle
    i_req = 1'b1; i_addr = 32'h10; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("f1_i_gnt", i_gnt, 1);
    chk("f1_d_gnt", d_gnt, 0);
    chk("f1_mem_req", mem_req, 1);
    chk("f1_mem_addr", mem_addr, 32'h10);
    chk("f1_mem_we", mem_we, 0);
    chk("f1_busy", busy, 1);
    chk("f1_valid_early", i_valid, 0);
    i_req = 1'b0;
    step();
    chk("f1_i_valid", i_valid, 1);
    chk("f1_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("f1_i_err", i_err, 0);
    chk("f1_mem_req_drop", mem_req, 0);
    chk("f1_busy_drop", busy, 0);
    step();
    chk("f1_idle_ack_ignored", {busy, i_valid, d_valid}, 0);

    // collision: store wins, fetch follows after one idle cycle
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h5;
    step();
    chk("col_gnts", {i_gnt, d_gnt}, 2'b01);
    chk("col_mem_we", mem_we, 1);
    chk("col_mem_wdata", mem_wdata, 32'h5);
    chk("col_mem_addr", mem_addr, 32'h40);
    d_req = 1'b0;
    step();
    chk("col_d_valid", d_valid, 1);
    chk("col_d_rdata", d_rdata, 0);
    chk("col_gap_gnts", {i_gnt, d_gnt}, 0);
    step();
    chk("col_i_gnt", {i_gnt, d_gnt}, 2'b10);
    chk("col_i_addr", mem_addr, 32'h20);
    chk("col_i_we", mem_we, 0);
    i_req = 1'b0;
    step();
    chk("col_valids", {i_valid, d_valid}, 2'b10);
    step();

    // starvation: both held, pattern D D D D I repeats
    i_req = 1'b1; i_addr = 32'h24;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k % 2 == 0)
        chk($sformatf("stv_gnt%0d", k / 2), {i_gnt, d_gnt}, ((k / 2) % 5 == 4) ? 2'b10 : 2'b01);
      else begin
        chk($sformatf("stv_gap%0d", k / 2), {i_gnt, d_gnt}, 2'b00);
        chk($sformatf("stv_vld%0d", k / 2), {i_valid, d_valid}, ((k / 2) % 5 == 4) ? 2'b10 : 2'b01);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
    chk("stv_idle", {busy, i_gnt, d_gnt}, 0);

    // slow memory: ack on the 7th cycle of mem_req; payload change after gnt ignored
    mem_ack = 1'b0; mem_rdata = 32'h12345678;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    step();
    chk("slow_d_gnt", d_gnt, 1);
    d_req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("slow_req_c%0d", c), {mem_req, busy, d_valid}, 3'b110);
      if (c == 3) d_addr = 32'h99;
      if (c == 7) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    chk("slow_d_valid", d_valid, 1);
    chk("slow_d_rdata", d_rdata, 32'h12345678);
    chk("slow_d_err", d_err, 0);
    chk("slow_mem_req", {mem_req, busy}, 0);
    chk("slow_addr_held", mem_addr, 32'h80);
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
    step();
    d_req = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("wd_req_c%0d", c), mem_req, 1);
      step();
    end
    chk("wd_mem_req_drop", mem_req, 0);
    chk("wd_d_valid", d_valid, 1);
    chk("wd_d_err", d_err, 1);
    chk("wd_d_rdata", d_rdata, 0);
    step();
    d_req = 1'b1;
    step();
    d_req = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("wd2_req_c%0d", c), mem_req, 1);
      if (c == 16) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    chk("wd2_d_valid", d_valid, 1);
    chk("wd2_d_err", d_err, 0);
    chk("wd2_d_rdata", d_rdata, 32'h12345678);
    step();
`endif

    // reset during DBUSY, then a fresh fetch
    mem_ack = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h50; d_wdata = 32'hAA;
    step();
    chk("rm_d_gnt", {d_gnt, mem_req}, 2'b11);
    d_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("rm_async_mem_req", mem_req, 0);
    chk("rm_async_busy", busy, 0);
    chk("rm_async_pulses", {i_gnt, d_gnt, i_valid, d_valid}, 0);
    chk("rm_async_mem_we", mem_we, 0);
    step();
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    i_req = 1'b1; i_addr = 32'h60;
    step();
    chk("rm_i_gnt", {i_gnt, d_gnt}, 2'b10);
    chk("rm_i_addr", mem_addr, 32'h60);
    chk("rm_no_dvalid", d_valid, 0);
    i_req = 1'b0;
    step();
    chk("rm_i_valid", {i_valid, d_valid}, 2'b10);
    chk("rm_i_rdata", i_rdata, 32'hCAFEF00D);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
